// File: rtl/rf_capture_buf_if.sv
// rtl/rf_capture_buf_if.sv - sample stream and readback port bundle for rf_capture_buf
interface rf_capture_buf_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output s_valid, s_data, rd_en, rd_addr,
        input  s_ready, rd_data, rd_valid
    );

    modport slave (
        input  s_valid, s_data, rd_en, rd_addr,
        output s_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/rf_capture_buf.sv
// rtl/rf_capture_buf.sv - arm/trigger RF frame capture into block RAM with registered readback
module rf_capture_buf #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 24100,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig,
    rf_capture_buf_if.slave   bus,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic              rd_v;
    logic              wr_fire;
    logic              rd_ok;
    logic              rd_in_range;

    // count doubles as the write pointer: both clear on arm and advance per accepted beat
    assign wr_fire     = (state == CAPTURE) && bus.s_valid;
    assign rd_ok       = bus.rd_en && ((state == IDLE) || (state == DONE));
    assign rd_in_range = {1'b0, bus.rd_addr} < LIMIT;

    assign bus.s_ready  = (state == CAPTURE);
    assign bus.rd_data  = rd_q;
    assign bus.rd_valid = rd_v;
    assign busy         = (state == ARMED) || (state == CAPTURE);
    assign done         = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            if (wr_fire)
                count <= count + 1'b1;
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (arm) begin
                        state <= ARMED;
                        count <= '0;
                    end
                    ARMED: if (trig)
                        state <= CAPTURE;
                    CAPTURE: if (wr_fire && (count == LAST))
                        state <= DONE;
                    DONE: if (arm) begin
                        state <= ARMED;
                        count <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // RAM write port has no reset so it maps onto block RAM; reset only blocks the write
    always_ff @(posedge clk) begin
        if (wr_fire && !reset)
            mem[count[IDX_W-1:0]] <= bus.s_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q <= '0;
            rd_v <= 1'b0;
        end else begin
            rd_v <= rd_ok;
            if (rd_ok)
                rd_q <= rd_in_range ? mem[bus.rd_addr[IDX_W-1:0]] : '0;
        end
    end
endmodule

// File: tb/tb_rf_capture_buf.sv
// tb/tb_rf_capture_buf.sv - directed scoreboard bench for rf_capture_buf (DEPTH 8 and full size)
module tb_rf_capture_buf;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic arm8, abort8, trig8, armb, abortb, trigb;
    logic busy8, done8, busyb, doneb;
    logic [4:0]  count8;
    logic [15:0] countb;

    rf_capture_buf_if #(.DATA_W(16), .ADDR_W(4))  b8 ();
    rf_capture_buf_if #(.DATA_W(16), .ADDR_W(15)) bb ();

    rf_capture_buf #(.DATA_W(16), .DEPTH(8), .ADDR_W(4)) dut8 (
        .clk(clk), .reset(reset), .arm(arm8), .abort(abort8), .trig(trig8),
        .bus(b8), .busy(busy8), .done(done8), .count(count8)
    );

    rf_capture_buf #(.DATA_W(16), .DEPTH(24100), .ADDR_W(15)) dutb (
        .clk(clk), .reset(reset), .arm(armb), .abort(abortb), .trig(trigb),
        .bus(bb), .busy(busyb), .done(doneb), .count(countb)
    );

    int          errors = 0;
    int          checks = 0;
    logic [15:0] m8 [8];
    logic [15:0] q8 [$];
    logic [15:0] qb [$];
    bit          cap8 = 1'b0;
    int          cnt8 = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat8(input logic v, input logic [15:0] d);
        b8.s_valid = v;
        b8.s_data  = d;
        if (v && cap8) begin
            m8[cnt8] = d;
            cnt8++;
            if (cnt8 == 8) cap8 = 1'b0;
        end
        step();
        check("count8", 32'(count8), 32'(cnt8));
    endtask

    task automatic burst8(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            b8.rd_en   = 1'b1;
            b8.rd_addr = 4'(a);
            q8.push_back((a < 8) ? m8[a] : 16'h0000);
            step();
            check("rd8_valid", 32'(b8.rd_valid), 32'd1);
            check("rd8_data", 32'(b8.rd_data), 32'(q8.pop_front()));
        end
        b8.rd_en = 1'b0;
        step();
        check("rd8_pulse", 32'(b8.rd_valid), 32'd0);
    endtask

    task automatic readb(input int a);
        bb.rd_en   = 1'b1;
        bb.rd_addr = 15'(a);
        qb.push_back((a < 24100) ? 16'(a) : 16'h0000);
        step();
        bb.rd_en = 1'b0;
        check("rdb_valid", 32'(bb.rd_valid), 32'd1);
        check("rdb_data", 32'(bb.rd_data), 32'(qb.pop_front()));
    endtask

    initial begin
        reset = 1'b1;
        {arm8, abort8, trig8, armb, abortb, trigb} = '0;
        b8.s_valid = 0; b8.s_data = '0; b8.rd_en = 0; b8.rd_addr = '0;
        bb.s_valid = 0; bb.s_data = '0; bb.rd_en = 0; bb.rd_addr = '0;
        step();
        step();
        reset = 1'b0;
        check("rst_ready", 32'(b8.s_ready), 0);
        check("rst_busy", 32'(busy8), 0);
        check("rst_done", 32'(done8), 0);
        check("rst_count", 32'(count8), 0);
        check("rst_rdvalid", 32'(b8.rd_valid), 0);
        check("rst_rddata", 32'(b8.rd_data), 0);

        // trig in IDLE does nothing
        trig8 = 1'b1; step(); trig8 = 1'b0;
        check("idle_trig_busy", 32'(busy8), 0);

        arm8 = 1'b1; step(); arm8 = 1'b0;
        check("arm_busy", 32'(busy8), 1);
        check("armed_ready", 32'(b8.s_ready), 0);
        b8.rd_en = 1'b1; b8.rd_addr = 4'd0; step();
        check("armed_rdvalid", 32'(b8.rd_valid), 0);
        check("armed_rddata", 32'(b8.rd_data), 0);

        // sample present on the trig cycle must not be captured
        trig8 = 1'b1; b8.s_valid = 1'b1; b8.s_data = 16'hDEAD; step(); trig8 = 1'b0;
        check("trig_ready", 32'(b8.s_ready), 1);
        check("trig_count", 32'(count8), 0);
        cap8 = 1'b1; cnt8 = 0;
        for (int i = 0; i < 8; i++) begin
            check("cap_ready", 32'(b8.s_ready), 1);
            beat8(1'b1, 16'h0100 + 16'(i));
            check("cap_rdvalid", 32'(b8.rd_valid), 0);
        end
        b8.rd_en = 1'b0;
        check("full_done", 32'(done8), 1);
        check("full_ready", 32'(b8.s_ready), 0);
        check("full_busy", 32'(busy8), 0);
        beat8(1'b1, 16'hBEEF);
        beat8(1'b0, 16'h0000);
        burst8(0, 7);
        burst8(9, 9);

        // reset then offer samples while idle
        reset = 1'b1; step(); step(); reset = 1'b0;
        cap8 = 1'b0; cnt8 = 0;
        for (int i = 0; i < 5; i++) begin
            check("idle_ready", 32'(b8.s_ready), 0);
            beat8(1'b1, 16'hAAAA);
            check("idle_done", 32'(done8), 0);
        end
        b8.s_valid = 1'b0;
        burst8(0, 0);

        // gapped capture then abort after 3 accepted beats
        arm8 = 1'b1; step(); arm8 = 1'b0;
        trig8 = 1'b1; step(); trig8 = 1'b0;
        cap8 = 1'b1; cnt8 = 0;
        for (int i = 0; i < 5; i++)
            beat8(((i % 2) == 0), 16'h0200 + 16'(i));
        b8.s_valid = 1'b0;
        abort8 = 1'b1; step(); abort8 = 1'b0;
        cap8 = 1'b0;
        check("abort_busy", 32'(busy8), 0);
        check("abort_count", 32'(count8), 3);
        check("abort_ready", 32'(b8.s_ready), 0);
        burst8(0, 4);

        // re-arm restarts at 0; abort on the final beat still writes it
        arm8 = 1'b1; step(); arm8 = 1'b0;
        check("rearm_count", 32'(count8), 0);
        trig8 = 1'b1; step(); trig8 = 1'b0;
        cap8 = 1'b1; cnt8 = 0;
        for (int i = 0; i < 7; i++)
            beat8(1'b1, 16'h0300 + 16'(i));
        abort8 = 1'b1;
        beat8(1'b1, 16'h0307);
        abort8 = 1'b0;
        b8.s_valid = 1'b0;
        check("abortlast_done", 32'(done8), 0);
        check("abortlast_busy", 32'(busy8), 0);
        burst8(0, 7);

        // full-size ramp
        armb = 1'b1; step(); armb = 1'b0;
        trigb = 1'b1; step(); trigb = 1'b0;
        for (int i = 0; i < 24100; i++) begin
            bb.s_valid = 1'b1;
            bb.s_data  = 16'(i);
            step();
            if (i == 24098) begin
                check("big_count_pre", 32'(countb), 24099);
                check("big_done_pre", 32'(doneb), 0);
            end
        end
        check("big_done", 32'(doneb), 1);
        check("big_count", 32'(countb), 24100);
        check("big_ready", 32'(bb.s_ready), 0);
        bb.s_data = 16'hFFFF;
        step(); step();
        bb.s_valid = 1'b0;
        check("big_extra_count", 32'(countb), 24100);
        readb(24099);
        check("big_last_word", 32'(bb.rd_data), 32'h5E23);
        readb(0);
        readb(12345);
        readb(24100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rf_capture_buf.md
# rf_capture_buf

Capture-side counterpart of the RF sample player: records a stream of 16-bit RF samples into on-chip block RAM and makes them available for random-access readback. It sits at the ADC/beamformer output of the ultrasound chain. After an arm/trigger sequence it stores exactly DEPTH consecutive samples, then freezes so that a host or a later playback stage can read the frame out.

## Interface
- DATA_W, 16, sample width in bits
- DEPTH, 24100, samples per captured frame
- ADDR_W, 15, address width; 2^ADDR_W >= DEPTH
- clk  in  1  clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high
- arm  in  1  one-cycle pulse; arms a new capture
- abort  in  1  one-cycle pulse; cancels arm or capture and returns to IDLE
- trig  in  1  starts recording when armed
- s_valid  in  1  input sample valid
- s_data  in  DATA_W  input sample
- s_ready  out  1  block accepts a sample this cycle
- rd_en  in  1  readback request
- rd_addr  in  ADDR_W  readback address
- rd_data  out  DATA_W  readback data, registered
- rd_valid  out  1  rd_data is valid this cycle
- busy  out  1  state is ARMED or CAPTURE
- done  out  1  a full frame is stored (state DONE)
- count  out  ADDR_W+1  number of samples written in the current or last frame

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE: arm -> ARMED. trig is ignored.
- ARMED: trig -> CAPTURE. abort -> IDLE. arm is ignored.
- CAPTURE: when s_valid && s_ready, write s_data to mem[wr_ptr], then increment wr_ptr and count. The write with wr_ptr == DEPTH-1 moves the block to DONE. abort -> IDLE, and count keeps its partial value. trig and arm are ignored.
- DONE: holds the frame. arm -> ARMED. abort -> IDLE.
- Any arm that enters ARMED clears wr_ptr and count to 0 on that edge.
- Priority in the same cycle: reset > abort > arm/trig. If abort and the final write coincide, the write happens and the state goes to IDLE with count = DEPTH.
- s_ready = 1 only in CAPTURE. It is combinational from state. Samples offered outside CAPTURE are dropped with no flag.
- Samples are never written past DEPTH-1. There is no wrap-around within a frame.
- Readback is accepted only in IDLE or DONE. If rd_en is high in ARMED or CAPTURE, rd_valid stays 0 and rd_data holds its value.
- If rd_addr >= DEPTH, rd_data = 0 and rd_valid = 1.
- Memory contents are not cleared by reset or by arm. Stale data persists until overwritten.
- Reset values: state IDLE, wr_ptr 0, count 0, rd_data 0, rd_valid 0. This gives s_ready 0, busy 0, done 0.

## Timing
- arm at cycle t -> busy = 1 at t+1.
- trig at cycle t (while ARMED) -> s_ready = 1 at t+1. A sample present at cycle t is not captured.
- Capture throughput: 1 sample per clock.
- The frame completes on the edge of the DEPTH-th accepted sample. done = 1 and s_ready = 0 from the next cycle. Minimum arm-to-done time is DEPTH+2 cycles.
- count updates on the same edge as the write. It is visible the cycle after the accepted beat.
- Read latency: rd_en/rd_addr at cycle t -> rd_data and rd_valid at t+1. Back-to-back reads run one per cycle.
- rd_valid is a single-cycle pulse per accepted request.
- Reset during CAPTURE: on the next edge the block is in IDLE and count = 0. Words already in memory remain.
- The memory is a single synchronous-write, synchronous-read RAM that infers block RAM. Writes and reads never overlap because they are legal in disjoint states.

## Test plan
- Reset then idle: with reset high for 2 cycles, then s_valid = 1 and s_data = 16'hAAAA for 5 cycles -> s_ready = 0, count = 0, done = 0, and no write occurs (a later readback of addr 0 returns prior content).
- Basic capture (DEPTH = 8): arm, trig, then 8 beats s_data = 16'h0100..16'h0107 -> done = 1 one cycle after the 8th beat, count = 8. Reads of addr 0..7 return 16'h0100..16'h0107 with 1-cycle latency. A read of addr 9 returns 16'h0000 with rd_valid = 1.
- Backpressure gaps: s_valid toggling 1,0,1,0 during CAPTURE -> only valid beats are stored, contiguously, and count advances only on accepted beats.
- Abort mid-capture: abort after 3 beats -> state IDLE, count = 3, s_ready = 0. A re-arm clears count to 0 and the next frame starts at addr 0.
- Illegal reads: rd_en in ARMED and in CAPTURE -> rd_valid = 0 throughout. trig in IDLE -> no state change.
- Full-size run (DEPTH = 24100): stream the ramp 0..24099 -> done after the 24100th beat, count = 24100, mem[24099] = 16'h5E23, and extra beats after done are dropped.
